// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the three-source round-robin mux arbiter.
package mux_arbiter_pkg;

    localparam int unsigned NUM_SRC       = 3;
    localparam int unsigned PTR_W         = 2;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DEF_DATA_W    = 4;
    localparam int unsigned DEF_MAX_BEATS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Convert a one-hot source vector into its source index (0-based).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot winner searching from the
// source after the last-granted pointer.
module mux_arbiter_rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_gnt
);

    // Priority order rotates so the source after i_ptr is checked first.
    always_comb begin
        o_gnt = '0;
        case (i_ptr)
            2'd0: begin
                if      (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            2'd1: begin
                if      (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mux_arbiter.sv
// Three-source round-robin arbiter with a registered data mux.
// Optional feature macro: MUX_ARB_BEAT_LIMIT_EN (forces release after
// MAX_BEATS grant cycles). Default build holds a grant while req stays high.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         req,
    input  logic [DATA_W-1:0]  in1,
    input  logic [DATA_W-1:0]  in2,
    input  logic [DATA_W-1:0]  in3,
    output logic               sel1,
    output logic               sel2,
    output logic               sel3,
    output logic [DATA_W-1:0]  mux_op,
    output logic               op_valid,
    output logic               busy
);

`ifdef MUX_ARB_BEAT_LIMIT_EN
    localparam bit LP_LIMIT_EN = 1'b1;
`else
    localparam bit LP_LIMIT_EN = 1'b0;
`endif

    // Count value seen on the final allowed grant cycle.
    localparam logic [CNT_W-1:0] LP_LAST_BEAT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

    state_e              r_state;
    logic [NUM_SRC-1:0]  r_sel;
    logic [PTR_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [DATA_W-1:0]   r_mux_op;
    logic                r_op_valid;

    logic [NUM_SRC-1:0]  w_gnt;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_req_drop;
    logic                w_limit_hit;
    logic                w_release;

    mux_arbiter_rr_pick u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Data mux driven by the registered one-hot select.
    always_comb begin
        w_sel_data = '0;
        case (r_sel)
            3'b001:  w_sel_data = in1;
            3'b010:  w_sel_data = in2;
            3'b100:  w_sel_data = in3;
            default: w_sel_data = '0;
        endcase
    end

    // Release when the owner drops its request or the beat budget is spent;
    // both at once still produce a single release.
    assign w_req_drop  = ~|(req & r_sel);
    assign w_limit_hit = LP_LIMIT_EN && (r_beat_cnt == LP_LAST_BEAT);
    assign w_release   = w_req_drop | w_limit_hit;

    // Arbiter FSM with registered grant, data and valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ptr      <= 2'd2;
            r_beat_cnt <= '0;
            r_mux_op   <= '0;
            r_op_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_op_valid <= 1'b0;
                    if (|req) begin
                        r_state    <= GRANT;
                        r_sel      <= w_gnt;
                        r_beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    r_mux_op   <= w_sel_data;
                    r_op_valid <= 1'b1;
                    if (r_beat_cnt != LP_CNT_MAX) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (w_release) begin
                        r_state <= IDLE;
                        r_sel   <= '0;
                        r_ptr   <= onehot_to_idx(r_sel);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    assign sel1     = r_sel[0];
    assign sel2     = r_sel[1];
    assign sel3     = r_sel[2];
    assign mux_op   = r_mux_op;
    assign op_valid = r_op_valid;
    assign busy     = (r_state == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a transaction-level model predicts
// grants and beats; a monitor compares DUT outputs after every clock edge.
module tb_mux_arbiter;

    localparam int unsigned DW = 4;
    localparam int          MB = 4;
`ifdef MUX_ARB_BEAT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [2:0]    req   = 3'b000;
    logic [DW-1:0] in1   = 4'b0001;
    logic [DW-1:0] in2   = 4'b0010;
    logic [DW-1:0] in3   = 4'b0100;
    logic          sel1, sel2, sel3, op_valid, busy;
    logic [DW-1:0] mux_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]    sel;
        logic          valid;
        logic [DW-1:0] op;
    } cyc_t;

    cyc_t          cyc_q[$];
    logic [DW-1:0] beat_q[$];

    // Model: owner 0 = nobody, otherwise source number 1..3.
    int            owner = 0;
    int            last  = 3;
    int            beats = 0;
    logic [DW-1:0] m_op  = '0;

    always #5 clk = ~clk;

    mux_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .sel1     (sel1),
        .sel2     (sel2),
        .sel3     (sel3),
        .mux_op   (mux_op),
        .op_valid (op_valid),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] src_data(input int s);
        if (s == 1) return in1;
        if (s == 2) return in2;
        return in3;
    endfunction

    function automatic bit req_of(input int s);
        if (s == 1) return req[0];
        if (s == 2) return req[1];
        return req[2];
    endfunction

    // Predict the effect of the coming rising edge from the inputs now driven.
    task automatic model_edge();
        logic v;
        cyc_t c;
        v = 1'b0;
        if (owner == 0) begin
            for (int k = 1; k <= 3; k++) begin
                int s;
                s = (last + k - 1) % 3 + 1;
                if (owner == 0 && req_of(s)) begin
                    owner = s;
                    beats = 0;
                end
            end
        end else begin
            v    = 1'b1;
            m_op = src_data(owner);
            beat_q.push_back(m_op);
            beats++;
            if (!req_of(owner) || (LIMIT_EN && beats >= MB)) begin
                last  = owner;
                owner = 0;
            end
        end
        c.sel   = (owner == 0) ? 3'b000 : 3'(1 << (owner - 1));
        c.valid = v;
        c.op    = m_op;
        cyc_q.push_back(c);
    endtask

    task automatic step(input logic [2:0] r, input bit rnd);
        @(negedge clk);
        req = r;
        if (rnd) begin
            in1 = DW'($urandom);
            in2 = DW'($urandom);
            in3 = DW'($urandom);
        end else begin
            in1 = 4'b0001;
            in2 = 4'b0010;
            in3 = 4'b0100;
        end
        model_edge();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"},   32'({sel3, sel2, sel1}), 32'd0);
        check({tag, "_valid"}, 32'(op_valid),           32'd0);
        check({tag, "_op"},    32'(mux_op),             32'd0);
        check({tag, "_busy"},  32'(busy),               32'd0);
    endtask

    // Assert reset mid-cycle, verify the asynchronous clear, then release.
    task automatic do_reset(input logic [2:0] r_after);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        owner = 0;
        last  = 3;
        beats = 0;
        m_op  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = r_after;
        model_edge();
    endtask

    // Monitor: pop expectations after every edge, beats only when valid.
    initial begin
        cyc_t c;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check_zero("in_rst");
            end else if (cyc_q.size() == 0) begin
                check("cyc_q_underrun", 32'd0, 32'd1);
            end else begin
                c = cyc_q.pop_front();
                check("sel",   32'({sel3, sel2, sel1}), 32'(c.sel));
                check("valid", 32'(op_valid),           32'(c.valid));
                check("busy",  32'(busy),               32'(c.sel != 3'b000));
                if (!op_valid) check("hold_op", 32'(mux_op), 32'(c.op));
                if (op_valid) begin
                    if (beat_q.size() == 0) check("beat_underrun", 32'd0, 32'd1);
                    else                    check("beat_data", 32'(mux_op), 32'(beat_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] r;
        #1 rst_n = 1'b0;
        #1 check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 3'b000;
        model_edge();

        // Single source burst of three cycles.
        repeat (3) step(3'b001, 1'b0);
        repeat (3) step(3'b000, 1'b0);

        // Two requesters, lower index held for ten cycles.
        repeat (10) step(3'b011, 1'b0);
        repeat (6)  step(3'b010, 1'b0);
        repeat (2)  step(3'b000, 1'b0);

        // All requesting continuously.
        repeat (20) step(3'b111, 1'b0);
        repeat (2)  step(3'b000, 1'b0);

        // Reset in the middle of a grant, then regrant.
        repeat (4) step(3'b001, 1'b0);
        do_reset(3'b001);
        repeat (4) step(3'b001, 1'b0);
        repeat (2) step(3'b000, 1'b0);

        // Owner drops on the fourth beat with another source waiting.
        step(3'b001, 1'b0);
        repeat (3) step(3'b011, 1'b0);
        repeat (6) step(3'b010, 1'b0);
        repeat (2) step(3'b000, 1'b0);

        // Randomized requests and data with a reset in the middle.
        r = 3'b000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            if (i == 200) do_reset(r);
            else          step(r, 1'b1);
        end
        repeat (3) step(3'b000, 1'b1);

        @(negedge clk);
        check("cyc_q_left",  32'(cyc_q.size()),  32'd0);
        check("beat_q_left", 32'(beat_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
